// File: rtl/rtc_time_setter.sv
// Time-set controller for the DS1302 RTC: edits hour/minute/second in BCD from
// debounced Mode/Up/Down pulses and hands the result to the driver via wrReq/wrAck.
module rtc_time_setter #(
    parameter int TIMEOUT_MS    = 10000,
    parameter int BLINK_MS      = 500,
    parameter int WR_TIMEOUT_MS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btnMode,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic [7:0] curHour,
    input  logic [7:0] curMin,
    input  logic [7:0] curSec,
    output logic [7:0] setHour,
    output logic [7:0] setMin,
    output logic [7:0] setSec,
    output logic [1:0] editMode,
    output logic       blink,
    output logic       wrReq,
    input  logic       wrAck,
    output logic       wrErr
);

    localparam int IDLE_W  = $clog2(TIMEOUT_MS + 1);
    localparam int BLINK_W = $clog2(BLINK_MS + 1);
    localparam int WR_W    = $clog2(WR_TIMEOUT_MS + 1);

    typedef enum logic [2:0] {IDLE, EDIT_H, EDIT_M, EDIT_S, WRITE} state_t;

    state_t               state, stateNxt;
    logic [IDLE_W-1:0]    idleCnt, idleCntNxt;
    logic [BLINK_W-1:0]   blinkCnt, blinkCntNxt;
    logic [WR_W-1:0]      wrCnt, wrCntNxt;
    logic [7:0]           setHourNxt, setMinNxt, setSecNxt;
    logic [1:0]           editModeNxt;
    logic                 blinkNxt, wrReqNxt, wrErrNxt;
    logic                 anyBtn, fieldUp, fieldDown;

    // Out-of-range values (including invalid BCD) wrap to 00 on increment.
    function automatic logic [7:0] bcdInc(input logic [7:0] v, input logic [7:0] maxV);
        if (v >= maxV)           return 8'h00;
        else if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
        else                     return v + 8'h01;
    endfunction

    function automatic logic [7:0] bcdDec(input logic [7:0] v, input logic [7:0] maxV);
        if (v == 8'h00 || v > maxV) return maxV;
        else if (v[3:0] == 4'h0)    return {v[7:4] - 4'h1, 4'h9};
        else                        return v - 8'h01;
    endfunction

    function automatic logic isEdit(input state_t s);
        return (s == EDIT_H) || (s == EDIT_M) || (s == EDIT_S);
    endfunction

    assign anyBtn    = btnMode | btnUp | btnDown;
    assign fieldUp   = btnUp & ~btnDown & ~btnMode;
    assign fieldDown = btnDown & ~btnUp & ~btnMode;

    always_comb begin
        stateNxt    = state;
        setHourNxt  = setHour;
        setMinNxt   = setMin;
        setSecNxt   = setSec;
        idleCntNxt  = idleCnt;
        blinkCntNxt = blinkCnt;
        blinkNxt    = blink;
        wrCntNxt    = wrCnt;
        wrErrNxt    = 1'b0;

        case (state)
            IDLE: begin
                if (btnMode) begin
                    setHourNxt = curHour;
                    setMinNxt  = curMin;
                    setSecNxt  = curSec;
                    stateNxt   = EDIT_H;
                end
            end
            EDIT_H, EDIT_M, EDIT_S: begin
                if (btnMode) begin
                    case (state)
                        EDIT_H:  stateNxt = EDIT_M;
                        EDIT_M:  stateNxt = EDIT_S;
                        default: stateNxt = WRITE;
                    endcase
                end else if (fieldUp || fieldDown) begin
                    case (state)
                        EDIT_H:  setHourNxt = fieldUp ? bcdInc(setHour, 8'h23) : bcdDec(setHour, 8'h23);
                        EDIT_M:  setMinNxt  = fieldUp ? bcdInc(setMin, 8'h59)  : bcdDec(setMin, 8'h59);
                        default: setSecNxt  = fieldUp ? bcdInc(setSec, 8'h59)  : bcdDec(setSec, 8'h59);
                    endcase
                end

                // A button in the same cycle as a tick wins: the count restarts.
                if (anyBtn) begin
                    idleCntNxt = '0;
                end else if (tick) begin
                    if (idleCnt == IDLE_W'(TIMEOUT_MS - 1)) stateNxt = IDLE;
                    else idleCntNxt = idleCnt + IDLE_W'(1);
                end

                if (btnUp || btnDown) begin
                    blinkNxt    = 1'b1;
                    blinkCntNxt = '0;
                end else if (tick) begin
                    if (blinkCnt == BLINK_W'(BLINK_MS - 1)) begin
                        blinkNxt    = ~blink;
                        blinkCntNxt = '0;
                    end else begin
                        blinkCntNxt = blinkCnt + BLINK_W'(1);
                    end
                end
            end
            WRITE: begin
                if (wrAck) begin
                    stateNxt = IDLE;
                end else if (tick) begin
                    if (wrCnt == WR_W'(WR_TIMEOUT_MS - 1)) begin
                        stateNxt = IDLE;
                        wrErrNxt = 1'b1;
                    end else begin
                        wrCntNxt = wrCnt + WR_W'(1);
                    end
                end
            end
            default: stateNxt = IDLE;
        endcase

        // Every state entry restarts all timers and shows the new field.
        if (stateNxt != state) begin
            idleCntNxt  = '0;
            blinkCntNxt = '0;
            wrCntNxt    = '0;
            blinkNxt    = 1'b1;
        end
        if (!isEdit(stateNxt)) blinkNxt = 1'b0;

        case (stateNxt)
            EDIT_H:  editModeNxt = 2'd1;
            EDIT_M:  editModeNxt = 2'd2;
            EDIT_S:  editModeNxt = 2'd3;
            default: editModeNxt = 2'd0;
        endcase
        wrReqNxt = (stateNxt == WRITE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            setHour  <= 8'h00;
            setMin   <= 8'h00;
            setSec   <= 8'h00;
            editMode <= 2'd0;
            blink    <= 1'b0;
            wrReq    <= 1'b0;
            wrErr    <= 1'b0;
            idleCnt  <= '0;
            blinkCnt <= '0;
            wrCnt    <= '0;
        end else begin
            state    <= stateNxt;
            setHour  <= setHourNxt;
            setMin   <= setMinNxt;
            setSec   <= setSecNxt;
            editMode <= editModeNxt;
            blink    <= blinkNxt;
            wrReq    <= wrReqNxt;
            wrErr    <= wrErrNxt;
            idleCnt  <= idleCntNxt;
            blinkCnt <= blinkCntNxt;
            wrCnt    <= wrCntNxt;
        end
    end

endmodule

// File: tb/tb_rtc_time_setter.sv
// Directed bench for rtc_time_setter: inputs change and outputs are sampled on the falling clock edge.
module tb_rtc_time_setter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       btnMode = 1'b0;
    logic       btnUp = 1'b0;
    logic       btnDown = 1'b0;
    logic [7:0] curHour = 8'h00;
    logic [7:0] curMin = 8'h00;
    logic [7:0] curSec = 8'h00;
    logic [7:0] setHour, setMin, setSec;
    logic [1:0] editMode;
    logic       blink, wrReq, wrErr;
    logic       wrAck = 1'b0;

    int nChecks = 0;
    int nFail = 0;

    rtc_time_setter dut (
        .clk(clk), .rst(rst), .tick(tick),
        .btnMode(btnMode), .btnUp(btnUp), .btnDown(btnDown),
        .curHour(curHour), .curMin(curMin), .curSec(curSec),
        .setHour(setHour), .setMin(setMin), .setSec(setSec),
        .editMode(editMode), .blink(blink),
        .wrReq(wrReq), .wrAck(wrAck), .wrErr(wrErr)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1);
    end

    task automatic pressMode();
        btnMode = 1'b1; @(negedge clk); btnMode = 1'b0;
    endtask

    task automatic pressUp();
        btnUp = 1'b1; @(negedge clk); btnUp = 1'b0;
    endtask

    task automatic pressDown();
        btnDown = 1'b1; @(negedge clk); btnDown = 1'b0;
    endtask

    task automatic ackOnce();
        wrAck = 1'b1; @(negedge clk); wrAck = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        nChecks++; if (setHour !== 8'h00) begin nFail++; $display("FAIL reset_setHour got %h want 00", setHour); end
        nChecks++; if (setMin !== 8'h00) begin nFail++; $display("FAIL reset_setMin got %h want 00", setMin); end
        nChecks++; if (setSec !== 8'h00) begin nFail++; $display("FAIL reset_setSec got %h want 00", setSec); end
        nChecks++; if (editMode !== 2'd0) begin nFail++; $display("FAIL reset_editMode got %0d want 0", editMode); end
        nChecks++; if (blink !== 1'b0) begin nFail++; $display("FAIL reset_blink got %b want 0", blink); end
        nChecks++; if (wrReq !== 1'b0) begin nFail++; $display("FAIL reset_wrReq got %b want 0", wrReq); end
        nChecks++; if (wrErr !== 1'b0) begin nFail++; $display("FAIL reset_wrErr got %b want 0", wrErr); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_enter_wrap();
        curHour = 8'h23; curMin = 8'h59; curSec = 8'h58;
        pressUp();
        nChecks++; if (editMode !== 2'd0 || setHour !== 8'h00) begin nFail++; $display("FAIL idle_up_ignored got mode %0d hour %h want 0 00", editMode, setHour); end
        pressMode();
        nChecks++; if (editMode !== 2'd1) begin nFail++; $display("FAIL enter_editMode got %0d want 1", editMode); end
        nChecks++; if ({setHour, setMin, setSec} !== 24'h235958) begin nFail++; $display("FAIL enter_capture got %h want 235958", {setHour, setMin, setSec}); end
        nChecks++; if (blink !== 1'b1) begin nFail++; $display("FAIL enter_blink got %b want 1", blink); end
        pressUp();
        nChecks++; if (setHour !== 8'h00) begin nFail++; $display("FAIL hour_up_wrap got %h want 00", setHour); end
        pressDown();
        nChecks++; if (setHour !== 8'h23) begin nFail++; $display("FAIL hour_down_wrap got %h want 23", setHour); end
        pressDown();
        nChecks++; if (setHour !== 8'h22) begin nFail++; $display("FAIL hour_down got %h want 22", setHour); end
    endtask

    task automatic test_commit();
        logic reqDropped;
        pressMode();
        nChecks++; if (editMode !== 2'd2) begin nFail++; $display("FAIL commit_mode_m got %0d want 2", editMode); end
        pressMode();
        nChecks++; if (editMode !== 2'd3) begin nFail++; $display("FAIL commit_mode_s got %0d want 3", editMode); end
        pressMode();
        nChecks++; if (editMode !== 2'd0 || wrReq !== 1'b1) begin nFail++; $display("FAIL commit_write got mode %0d req %b want 0 1", editMode, wrReq); end
        nChecks++; if (blink !== 1'b0) begin nFail++; $display("FAIL commit_blink_write got %b want 0", blink); end
        reqDropped = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) pressUp(); else @(negedge clk);
            if (wrReq !== 1'b1) reqDropped = 1'b1;
        end
        nChecks++; if (reqDropped !== 1'b0) begin nFail++; $display("FAIL commit_req_hold got dropped %b want 0", reqDropped); end
        nChecks++; if ({setHour, setMin, setSec} !== 24'h225958) begin nFail++; $display("FAIL commit_frozen got %h want 225958", {setHour, setMin, setSec}); end
        ackOnce();
        nChecks++; if (wrReq !== 1'b0 || editMode !== 2'd0 || wrErr !== 1'b0) begin nFail++; $display("FAIL commit_ack got req %b mode %0d err %b want 0 0 0", wrReq, editMode, wrErr); end
        pressUp();
        nChecks++; if (setHour !== 8'h22 || editMode !== 2'd0) begin nFail++; $display("FAIL commit_idle got hour %h mode %0d want 22 0", setHour, editMode); end
    endtask

    task automatic test_bcd();
        curHour = 8'h12; curMin = 8'h09; curSec = 8'h75;
        pressMode();
        pressMode();
        nChecks++; if (editMode !== 2'd2 || setMin !== 8'h09) begin nFail++; $display("FAIL bcd_enter_m got mode %0d min %h want 2 09", editMode, setMin); end
        pressUp();
        nChecks++; if (setMin !== 8'h10) begin nFail++; $display("FAIL bcd_min_up got %h want 10", setMin); end
        pressDown();
        nChecks++; if (setMin !== 8'h09) begin nFail++; $display("FAIL bcd_min_down got %h want 09", setMin); end
        repeat (9) pressDown();
        nChecks++; if (setMin !== 8'h00) begin nFail++; $display("FAIL bcd_min_zero got %h want 00", setMin); end
        pressDown();
        nChecks++; if (setMin !== 8'h59) begin nFail++; $display("FAIL bcd_min_wrap got %h want 59", setMin); end
        nChecks++; if (setHour !== 8'h12) begin nFail++; $display("FAIL bcd_hour_untouched got %h want 12", setHour); end
        pressMode();
        nChecks++; if (editMode !== 2'd3 || setSec !== 8'h75) begin nFail++; $display("FAIL bcd_enter_s got mode %0d sec %h want 3 75", editMode, setSec); end
        pressUp();
        nChecks++; if (setSec !== 8'h00) begin nFail++; $display("FAIL bcd_sec_invalid_up got %h want 00", setSec); end
        pressMode();
        ackOnce();
        nChecks++; if (editMode !== 2'd0 || wrReq !== 1'b0) begin nFail++; $display("FAIL bcd_exit got mode %0d req %b want 0 0", editMode, wrReq); end
    endtask

    task automatic test_blink();
        curHour = 8'h05; curMin = 8'h06; curSec = 8'h07;
        pressMode();
        tick = 1'b1;
        repeat (499) @(negedge clk);
        tick = 1'b0;
        nChecks++; if (blink !== 1'b1) begin nFail++; $display("FAIL blink_before got %b want 1", blink); end
        tick = 1'b1; @(negedge clk); tick = 1'b0;
        nChecks++; if (blink !== 1'b0) begin nFail++; $display("FAIL blink_toggle got %b want 0", blink); end
        pressUp();
        nChecks++; if (blink !== 1'b1 || setHour !== 8'h06) begin nFail++; $display("FAIL blink_up_force got blink %b hour %h want 1 06", blink, setHour); end
        repeat (3) pressMode();
        ackOnce();
    endtask

    task automatic test_timeout();
        logic sawReq;
        curHour = 8'h01; curMin = 8'h02; curSec = 8'h03;
        pressMode();
        sawReq = 1'b0;
        tick = 1'b1;
        for (int i = 0; i < 9999; i++) begin
            @(negedge clk);
            if (wrReq !== 1'b0) sawReq = 1'b1;
        end
        nChecks++; if (editMode !== 2'd1) begin nFail++; $display("FAIL timeout_9999 got mode %0d want 1", editMode); end
        @(negedge clk);
        tick = 1'b0;
        nChecks++; if (editMode !== 2'd0 || wrReq !== 1'b0 || sawReq !== 1'b0) begin nFail++; $display("FAIL timeout_exit got mode %0d req %b sawReq %b want 0 0 0", editMode, wrReq, sawReq); end
        nChecks++; if ({setHour, setMin, setSec} !== 24'h010203) begin nFail++; $display("FAIL timeout_keep got %h want 010203", {setHour, setMin, setSec}); end
        pressMode();
        tick = 1'b1;
        repeat (9998) @(negedge clk);
        btnUp = 1'b1; @(negedge clk); btnUp = 1'b0;
        @(negedge clk);
        nChecks++; if (editMode !== 2'd1 || setHour !== 8'h02) begin nFail++; $display("FAIL timeout_restart got mode %0d hour %h want 1 02", editMode, setHour); end
        repeat (9998) @(negedge clk);
        nChecks++; if (editMode !== 2'd1) begin nFail++; $display("FAIL timeout_restart_9999 got mode %0d want 1", editMode); end
        @(negedge clk);
        tick = 1'b0;
        nChecks++; if (editMode !== 2'd0) begin nFail++; $display("FAIL timeout_restart_exit got mode %0d want 0", editMode); end
    endtask

    task automatic test_write_fail();
        int errCount;
        logic reqDropped;
        pressMode();
        repeat (3) pressMode();
        nChecks++; if (wrReq !== 1'b1) begin nFail++; $display("FAIL wrfail_req got %b want 1", wrReq); end
        errCount = 0;
        reqDropped = 1'b0;
        tick = 1'b1;
        for (int i = 0; i < 99; i++) begin
            @(negedge clk);
            if (wrErr === 1'b1) errCount++;
            if (wrReq !== 1'b1) reqDropped = 1'b1;
        end
        nChecks++; if (reqDropped !== 1'b0 || errCount != 0) begin nFail++; $display("FAIL wrfail_early got dropped %b errs %0d want 0 0", reqDropped, errCount); end
        @(negedge clk);
        tick = 1'b0;
        if (wrErr === 1'b1) errCount++;
        nChecks++; if (wrErr !== 1'b1 || wrReq !== 1'b0 || editMode !== 2'd0) begin nFail++; $display("FAIL wrfail_timeout got err %b req %b mode %0d want 1 0 0", wrErr, wrReq, editMode); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (wrErr === 1'b1) errCount++;
        end
        nChecks++; if (errCount != 1) begin nFail++; $display("FAIL wrfail_pulses got %0d want 1", errCount); end
        wrAck = 1'b1; @(negedge clk); wrAck = 1'b0;
        nChecks++; if (wrReq !== 1'b0 || editMode !== 2'd0 || wrErr !== 1'b0) begin nFail++; $display("FAIL wrfail_ack_idle got req %b mode %0d err %b want 0 0 0", wrReq, editMode, wrErr); end
    endtask

    task automatic test_simul_reset();
        curHour = 8'h10; curMin = 8'h20; curSec = 8'h30;
        pressMode();
        btnMode = 1'b1; btnUp = 1'b1; @(negedge clk); btnMode = 1'b0; btnUp = 1'b0;
        nChecks++; if (editMode !== 2'd2 || setHour !== 8'h10) begin nFail++; $display("FAIL simul_mode_up got mode %0d hour %h want 2 10", editMode, setHour); end
        btnUp = 1'b1; btnDown = 1'b1; @(negedge clk); btnUp = 1'b0; btnDown = 1'b0;
        nChecks++; if (editMode !== 2'd2 || setMin !== 8'h20) begin nFail++; $display("FAIL simul_up_down got mode %0d min %h want 2 20", editMode, setMin); end
        pressMode();
        pressMode();
        nChecks++; if (wrReq !== 1'b1) begin nFail++; $display("FAIL simul_write got req %b want 1", wrReq); end
        #2 rst = 1'b0;
        #1;
        nChecks++; if (wrReq !== 1'b0 || editMode !== 2'd0 || wrErr !== 1'b0 || blink !== 1'b0) begin nFail++; $display("FAIL async_reset_ctrl got req %b mode %0d err %b blink %b want 0 0 0 0", wrReq, editMode, wrErr, blink); end
        nChecks++; if ({setHour, setMin, setSec} !== 24'h000000) begin nFail++; $display("FAIL async_reset_time got %h want 000000", {setHour, setMin, setSec}); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pressMode();
        nChecks++; if (editMode !== 2'd1 || setSec !== 8'h30) begin nFail++; $display("FAIL after_reset_enter got mode %0d sec %h want 1 30", editMode, setSec); end
    endtask

    initial begin
        test_reset();
        test_enter_wrap();
        test_commit();
        test_bcd();
        test_blink();
        test_timeout();
        test_write_fail();
        test_simul_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/rtc_time_setter.md
Name: rtc_time_setter

Overview:
- Consumes the one-cycle debounced button pulses from the edge-detector stage (Mode/Up/Down) and lets the user edit hour/minute/second for the DS1302 RTC.
- Captures the current time on entry and walks hour -> minute -> second.
- Hands the edited BCD time to the DS1302 driver over a req/ack handshake.
- Drives edit-field select and blink outputs for the display mux.

Parameters:
TIMEOUT_MS, 10000, idle ticks in any edit state before abandoning edit without writing
BLINK_MS, 500, ticks per blink half-period of the field being edited
WR_TIMEOUT_MS, 100, ticks to wait for wrAck before declaring write failure

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (0 = reset)
tick  in  1  1 ms single-cycle strobe
btnMode  in  1  single-cycle pulse: enter edit / next field / commit
btnUp  in  1  single-cycle pulse: increment field
btnDown  in  1  single-cycle pulse: decrement field
curHour  in  8  current hour, BCD 00-23, from RTC read path
curMin  in  8  current minute, BCD 00-59
curSec  in  8  current second, BCD 00-59
setHour  out  8  edited hour, BCD
setMin  out  8  edited minute, BCD
setSec  out  8  edited second, BCD
editMode  out  2  0 = none, 1 = hour, 2 = minute, 3 = second
blink  out  1  1 = show edited field, 0 = blank; 0 outside edit states
wrReq  out  1  write request to DS1302 driver, level
wrAck  in  1  driver accepted write, level or pulse
wrErr  out  1  one-cycle pulse on write timeout

Behaviour:
- All outputs registered.
- Reset, async on rst=0: state IDLE; setHour/setMin/setSec = 8'h00; editMode = 0; blink = 0; wrReq = 0; wrErr = 0; all counters 0.
- States: IDLE, EDIT_H, EDIT_M, EDIT_S, WRITE.
- IDLE:
  - btnMode: load set* <= cur* and go to EDIT_H.
  - Up/Down ignored.
- EDIT_x:
  - btnMode advances EDIT_H -> EDIT_M -> EDIT_S -> WRITE.
  - btnUp/btnDown modify only the active field.
- Input priority in the same cycle:
  - btnMode beats Up/Down; the field is not modified on that cycle.
  - btnUp together with btnDown: no change, but counts as activity.
- BCD arithmetic, max = 23 for hour, 59 for min/sec:
  - Up: if field >= max (including invalid BCD) -> 00; else BCD +1 (x9 -> (x+1)0).
  - Down: if field == 00 or field > max -> max; else BCD -1 (x0 -> (x-1)9).
- editMode follows state (EDIT_H = 1, EDIT_M = 2, EDIT_S = 3) and updates the cycle after the pulse. It is 0 in IDLE and WRITE.
- Inactivity timer:
  - Clears on any button pulse and on state entry; counts tick strobes in EDIT_x.
  - On reaching TIMEOUT_MS: go to IDLE, no write, set* keep last values.
- Blink:
  - Forced 1 and blink counter cleared on edit-state entry and on any Up/Down.
  - Toggles after every BLINK_MS ticks while in EDIT_x.
- WRITE:
  - wrReq = 1 from the first cycle in WRITE.
  - set* frozen; all buttons ignored; inactivity timer inactive.
  - wrAck sampled 1 while in WRITE: wrReq = 0 and IDLE on the next cycle.
  - No ack after WR_TIMEOUT_MS ticks: wrReq = 0, wrErr = 1 for one cycle, go to IDLE.
  - wrAck outside WRITE ignored.
- A tick coincident with a button pulse: the button's counter clear wins.
- Reset mid-WRITE drops wrReq immediately; the driver must tolerate request withdrawal.

Test Plan:
- Enter and wrap hour: cur = 23:59:58, btnMode -> editMode = 1, set* = 23/59/58. Then btnUp -> setHour = 00; btnDown -> 23; btnDown -> 22.
- Full commit: from EDIT_H, press Mode three times -> editMode 1 -> 2 -> 3 -> 0 and wrReq = 1. wrAck on the 5th cycle -> wrReq = 0 the next cycle, state IDLE, wrErr stays 0.
- BCD boundary: EDIT_M with setMin = 09, btnUp -> 10; btnDown -> 09. Then setMin = 00, btnDown -> 59; force curSec = 8'h75 and enter -> in EDIT_S, btnUp -> 00.
- Timeout: enter edit, no buttons for 10000 ticks -> editMode = 0, wrReq never asserted. A btnUp at tick 9999 restarts the count, so no exit at 10000.
- Write failure: reach WRITE with wrAck held 0 for 100 ticks -> exactly one wrErr pulse, wrReq = 0, IDLE.
- Simultaneous and reset: btnMode + btnUp same cycle in EDIT_H -> field unchanged, goes to EDIT_M. rst = 0 during WRITE -> all outputs at reset values immediately.
